ahb_resp_mux: RTL and testbench

AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

---
 rtl/ahb_resp_mux.sv | 150 +++++++++++++++
 tb/tb_ahb_resp_mux.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave response multiplexer with a built-in default slave.
// Routes the selected slave's data-phase response to the master and answers unmapped transfers with a two-cycle ERROR.
module ahb_resp_mux #(
    parameter int NSLV = 3,
    parameter int DW   = 32
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NSLV-1:0]    HSEL,
    input  logic [1:0]         HTRANS,
    input  logic [NSLV*DW-1:0] HRDATA_S,
    input  logic [NSLV-1:0]    HREADYOUT_S,
    input  logic [NSLV-1:0]    HRESP_S,
    output logic [DW-1:0]      HRDATA,
    output logic               HREADY,
    output logic               HRESP,
    output logic               SEL_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    // Saturating count of set select bits: 0, 1, or 2 meaning "two or more".
    function automatic logic [1:0] sel_count(input logic [NSLV-1:0] sel);
        logic [1:0] cnt;
        cnt = 2'd0;
        for (int i = 0; i < NSLV; i++) begin
            cnt = (cnt == 2'd2) ? 2'd2 : (cnt + {1'b0, sel[i]});
        end
        return cnt;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NSLV-1:0] r_dsel;
    logic [NSLV-1:0] w_dsel_nxt;
    logic            r_sel_err;
    logic [1:0]      w_sel_cnt;
    logic            w_onehot;
    logic            w_multi;
    logic            w_xfer;
    logic            w_unmapped;
    logic            w_unused_htrans;

    assign w_sel_cnt       = sel_count(HSEL);
    assign w_onehot        = (w_sel_cnt == 2'd1);
    assign w_multi         = (w_sel_cnt == 2'd2);
    assign w_xfer          = HTRANS[1];
    assign w_unmapped      = w_xfer & ~w_onehot;
    assign w_unused_htrans = HTRANS[0];
    assign SEL_ERR         = r_sel_err;

    // FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; ERR2 always has HREADY=1 so it samples every cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (HREADY && w_unmapped) begin
                    w_state_nxt = ST_ERR1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            ST_ERR2: begin
                if (w_unmapped) begin
                    w_state_nxt = ST_ERR1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Data-phase select: loads only a one-hot select, holds across wait states.
    always_comb begin
        w_dsel_nxt = r_dsel;
        if (HREADY) begin
            if (w_onehot) begin
                w_dsel_nxt = HSEL & {NSLV{w_xfer}};
            end else begin
                w_dsel_nxt = {NSLV{1'b0}};
            end
        end else begin
            w_dsel_nxt = r_dsel;
        end
    end

    // Data-phase select and sticky multi-hot flag registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel    <= {NSLV{1'b0}};
            r_sel_err <= 1'b0;
        end else begin
            r_dsel    <= w_dsel_nxt;
            r_sel_err <= r_sel_err | (HREADY & w_xfer & w_multi);
        end
    end

    // Read-data AND-OR mux; yields zero when nothing is selected.
    always_comb begin
        HRDATA = {DW{1'b0}};
        for (int i = 0; i < NSLV; i++) begin
            HRDATA = HRDATA | (HRDATA_S[i*DW +: DW] & {DW{r_dsel[i]}});
        end
    end

    // Ready/response outputs: default-slave states override the selected slave.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (r_state)
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            ST_ERR2: begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end
            ST_IDLE: begin
                if (r_dsel != {NSLV{1'b0}}) begin
                    HREADY = |(HREADYOUT_S & r_dsel);
                    HRESP  = |(HRESP_S & r_dsel);
                end else begin
                    HREADY = 1'b1;
                    HRESP  = 1'b0;
                end
            end
            default: begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Scoreboard bench for ahb_resp_mux (NSLV=3, DW=32): per-cycle expected outputs are queued
// with the stimulus and compared on the falling edge.
module tb_ahb_resp_mux;

    logic        HCLK;
    logic        HRESETn;
    logic [2:0]  HSEL;
    logic [1:0]  HTRANS;
    logic [95:0] HRDATA_S;
    logic [2:0]  HREADYOUT_S;
    logic [2:0]  HRESP_S;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        SEL_ERR;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] rdata;
        logic        ready;
        logic        resp;
        logic        sel_err;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;

    ahb_resp_mux #(.NSLV(3), .DW(32)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .SEL_ERR     (SEL_ERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare the outputs of the current cycle away from the rising edge.
    always @(negedge HCLK) begin
        if (exp_q.size() != 0) begin
            cur_e = exp_q.pop_front();
            check_eq({cur_e.tag, ".rdata"}, {32'd0, HRDATA}, {32'd0, cur_e.rdata});
            check_eq({cur_e.tag, ".ready"}, {63'd0, HREADY}, {63'd0, cur_e.ready});
            check_eq({cur_e.tag, ".resp"},  {63'd0, HRESP},  {63'd0, cur_e.resp});
            check_eq({cur_e.tag, ".selerr"}, {63'd0, SEL_ERR}, {63'd0, cur_e.sel_err});
        end
    end

    task automatic step(input logic [2:0] sel, input logic [1:0] trans,
                        input logic [2:0] rdy, input logic [2:0] rsp,
                        input logic [31:0] ed, input logic er, input logic ep,
                        input logic es, input string tag);
        exp_t e;
        HSEL        = sel;
        HTRANS      = trans;
        HREADYOUT_S = rdy;
        HRESP_S     = rsp;
        e.rdata   = ed;
        e.ready   = er;
        e.resp    = ep;
        e.sel_err = es;
        e.tag     = tag;
        exp_q.push_back(e);
        @(negedge HCLK);
        @(posedge HCLK);
        #1;
    endtask

    localparam logic [31:0] D0 = 32'h11110000;
    localparam logic [31:0] D1 = 32'hDEADBEEF;
    localparam logic [31:0] D2 = 32'h22222222;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        HRESETn     = 1'b0;
        HSEL        = 3'b000;
        HTRANS      = 2'b00;
        HRDATA_S    = {D2, D1, D0};
        HREADYOUT_S = 3'b111;
        HRESP_S     = 3'b000;

        #3;
        check_eq("rst.rdata",  {32'd0, HRDATA}, 64'd0);
        check_eq("rst.ready",  {63'd0, HREADY}, 64'd1);
        check_eq("rst.resp",   {63'd0, HRESP},  64'd0);
        check_eq("rst.selerr", {63'd0, SEL_ERR}, 64'd0);
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Single read from slave 1
        step(3'b000, 2'b00, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "idle");
        step(3'b010, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "rd1_addr");
        step(3'b000, 2'b00, 3'b111, 3'b000, D1,    1'b1, 1'b0, 1'b0, "rd1_data");
        // Wait states on slave 2 while HSEL moves to slave 0
        step(3'b100, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "ws_addr");
        step(3'b001, 2'b10, 3'b011, 3'b000, D2,    1'b0, 1'b0, 1'b0, "ws1");
        step(3'b001, 2'b10, 3'b011, 3'b000, D2,    1'b0, 1'b0, 1'b0, "ws2");
        step(3'b001, 2'b10, 3'b011, 3'b000, D2,    1'b0, 1'b0, 1'b0, "ws3");
        step(3'b001, 2'b10, 3'b111, 3'b000, D2,    1'b1, 1'b0, 1'b0, "ws_done");
        step(3'b000, 2'b00, 3'b111, 3'b000, D0,    1'b1, 1'b0, 1'b0, "s0_data");
        // Slave ERROR response; unselected slaves' responses are ignored
        step(3'b010, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "se_addr");
        step(3'b010, 2'b10, 3'b111, 3'b101, D1,    1'b1, 1'b0, 1'b0, "se_ignore");
        step(3'b000, 2'b00, 3'b101, 3'b010, D1,    1'b0, 1'b1, 1'b0, "se_err1");
        step(3'b000, 2'b00, 3'b111, 3'b010, D1,    1'b1, 1'b1, 1'b0, "se_err2");
        // Unmapped access
        step(3'b000, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "um_addr");
        step(3'b000, 2'b00, 3'b111, 3'b000, 32'd0, 1'b0, 1'b1, 1'b0, "um_err1");
        step(3'b000, 2'b00, 3'b111, 3'b000, 32'd0, 1'b1, 1'b1, 1'b0, "um_err2");
        step(3'b000, 2'b00, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "um_okay");
        // Multi-hot select on an IDLE transfer is harmless
        step(3'b011, 2'b00, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "mh_idle");
        // Back-to-back unmapped, then slave 0
        step(3'b000, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "b2b_a1");
        step(3'b000, 2'b10, 3'b111, 3'b000, 32'd0, 1'b0, 1'b1, 1'b0, "b2b_err1a");
        step(3'b000, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b1, 1'b0, "b2b_err2a");
        step(3'b001, 2'b10, 3'b111, 3'b000, 32'd0, 1'b0, 1'b1, 1'b0, "b2b_err1b");
        step(3'b001, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b1, 1'b0, "b2b_err2b");
        step(3'b000, 2'b00, 3'b111, 3'b000, D0,    1'b1, 1'b0, 1'b0, "b2b_s0");
        // Multi-hot NONSEQ: error response and sticky flag
        step(3'b011, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "mh_addr");
        step(3'b000, 2'b00, 3'b111, 3'b000, 32'd0, 1'b0, 1'b1, 1'b1, "mh_err1");
        step(3'b010, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b1, 1'b1, "mh_err2");
        step(3'b000, 2'b00, 3'b111, 3'b000, D1,    1'b1, 1'b0, 1'b1, "mh_good");
        step(3'b000, 2'b00, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b1, "mh_sticky");
        // Reset asserted between edges while in ERR1
        step(3'b000, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b1, "re_addr");
        check_eq("re_pre.ready", {63'd0, HREADY}, 64'd0);
        check_eq("re_pre.resp",  {63'd0, HRESP},  64'd1);
        #1 HRESETn = 1'b0;
        #1;
        check_eq("re.ready",  {63'd0, HREADY},  64'd1);
        check_eq("re.resp",   {63'd0, HRESP},   64'd0);
        check_eq("re.rdata",  {32'd0, HRDATA},  64'd0);
        check_eq("re.selerr", {63'd0, SEL_ERR}, 64'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        step(3'b100, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "post_addr");
        step(3'b000, 2'b00, 3'b000, 3'b000, D2,    1'b0, 1'b0, 1'b0, "stall");
        // Reset asserted while slave 2 stalls
        check_eq("rs_pre.ready", {63'd0, HREADY}, 64'd0);
        #1 HRESETn = 1'b0;
        #1;
        check_eq("rs.ready", {63'd0, HREADY}, 64'd1);
        check_eq("rs.rdata", {32'd0, HRDATA}, 64'd0);
        check_eq("rs.resp",  {63'd0, HRESP},  64'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        step(3'b001, 2'b10, 3'b111, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, "rs_addr");
        step(3'b000, 2'b00, 3'b111, 3'b000, D0,    1'b1, 1'b0, 1'b0, "rs_data");

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
